// File: rtl/adder_host.sv
// Host-side UART initiator for the adder HCI link: sends a 4-byte operand frame (8N1)
// and collects the 3-byte sum/flags reply, reporting timeout or framing errors.
module adder_host #(
  parameter int SYS_CLK_FREQ   = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_opr1,
  input  logic [15:0] req_opr2,
  output logic        rsp_valid,
  output logic [15:0] rsp_ans,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic        tx,
  input  logic        rx
);
  localparam int CPB = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT_RSP = 2'd2, DONE = 2'd3;
  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;

  logic [1:0]    state;
  logic          run;
  logic [39:0]   frame;
  logic [5:0]    bit_idx;
  logic [CW-1:0] tx_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    rx_idx;
  logic [7:0]    ans_lo, ans_hi;

  logic          rx_s1, rx_s2, rx_d;
  logic [1:0]    rstate;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          stop_pt, byte_done, frame_err, armed, xfer;

  assign xfer      = req_valid && req_ready;
  assign req_ready = run && (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign tx        = (state == SEND) ? frame[bit_idx] : 1'b1;
  assign stop_pt   = (rstate == R_STOP) && (rx_cnt == CPB_M1);
  assign byte_done = stop_pt && rx_s2;
  assign frame_err = stop_pt && !rx_s2;
  // Receiver listens from the final tx stop bit so an eager responder is not lost.
  assign armed     = (state == WAIT_RSP) || ((state == SEND) && (bit_idx == 6'd39));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_d   <= 1'b1;
      rstate <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      case (rstate)
        R_IDLE: begin
          rx_cnt <= '0;
          if (rx_d && !rx_s2) rstate <= R_START;
        end
        R_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rstate <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt == CPB_M1) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rstate <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == CPB_M1) begin
            rx_cnt <= '0;
            rstate <= R_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Datapath registers carry no reset; they are only read after being written.
  always_ff @(posedge clk) begin
    if ((rstate == R_DATA) && (rx_cnt == CPB_M1)) rx_shift <= {rx_s2, rx_shift[7:1]};
    if (xfer)
      frame <= {1'b1, req_opr2[15:8], 1'b0, 1'b1, req_opr2[7:0], 1'b0,
                1'b1, req_opr1[15:8], 1'b0, 1'b1, req_opr1[7:0], 1'b0};
    if (armed && byte_done && (rx_idx == 2'd0)) ans_lo <= rx_shift;
    if (armed && byte_done && (rx_idx == 2'd1)) ans_hi <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= 1'b0;
      bit_idx   <= '0;
      tx_cnt    <= '0;
      to_cnt    <= '0;
      rx_idx    <= '0;
      rsp_ans   <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (armed && byte_done) rx_idx <= rx_idx + 1'b1;
      case (state)
        IDLE: begin
          if (xfer) begin
            state   <= SEND;
            bit_idx <= '0;
            tx_cnt  <= '0;
            rx_idx  <= '0;
          end
        end
        SEND: begin
          if (tx_cnt == CPB_M1) begin
            tx_cnt <= '0;
            if (bit_idx == 6'd39) begin
              state  <= WAIT_RSP;
              to_cnt <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        WAIT_RSP: begin
          if (frame_err || (!byte_done && (to_cnt == TO_M1))) begin
            state     <= DONE;
            rsp_ans   <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b1;
          end else if (byte_done && (rx_idx == 2'd2)) begin
            state     <= DONE;
            rsp_ans   <= {ans_hi, ans_lo};
            rsp_carry <= rx_shift[0];
            rsp_err   <= 1'b0;
          end else if (byte_done) begin
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_host.sv
// Bench for adder_host: acts as the board-side UART responder, decodes the command
// frame bit-by-bit and scores responses against a sum-based reference model.
module tb_adder_host;
  localparam int CPB = 16;
  localparam int TO  = 500;

  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rx = 1'b1;
  logic [15:0] req_opr1 = '0, req_opr2 = '0;
  logic        req_ready, rsp_valid, rsp_carry, rsp_err, tx;
  logic [15:0] rsp_ans;

  adder_host #(.SYS_CLK_FREQ(16), .BAUD_RATE(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opr1(req_opr1), .req_opr2(req_opr2), .rsp_valid(rsp_valid),
    .rsp_ans(rsp_ans), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .tx(tx), .rx(rx));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] ans; logic carry; logic err; int at; } rsp_t;
  rsp_t rsp_q[$];
  always @(negedge clk) if (rsp_valid) rsp_q.push_back('{rsp_ans, rsp_carry, rsp_err, cyc});

  typedef struct {
    logic [15:0] a, b;
    logic [7:0]  r0, r1, r2;
    int          bad;
    logic [15:0] ans;
    logic        carry, err;
  } vec_t;
  vec_t tbl[6];

  logic exp_bits[40];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_frame(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] by[4];
    by[0] = a[7:0]; by[1] = a[15:8]; by[2] = b[7:0]; by[3] = b[15:8];
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 10; j++)
        exp_bits[10*k+j] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : by[k][j-1];
  endtask

  task automatic check_tx(input int lo, input int hi, input int poke_at);
    int bad = 0;
    for (int i = lo; i < hi; i++) begin
      if (tx !== exp_bits[i/CPB]) bad++;
      if (i == poke_at) begin
        check("busy_ready", req_ready, 0);
        req_opr1 = 16'hAAAA; req_opr2 = 16'h5555; req_valid = 1'b1;
      end else if (i == poke_at + 1) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("tx_frame", bad, 0);
  endtask

  task automatic do_request(input logic [15:0] a, input logic [15:0] b, output int t0);
    check("req_ready_idle", req_ready, 1);
    req_opr1 = a; req_opr2 = b; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_opr1 = 16'($urandom); req_opr2 = 16'($urandom);
    t0 = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx = b[j];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_rsp(input int n0, input int limit, output bit got);
    for (int i = 0; i < limit && rsp_q.size() <= n0; i++) @(negedge clk);
    got = (rsp_q.size() > n0);
    if (!got) check("rsp_wait_bound", 0, 1);
  endtask

  task automatic run_txn(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                         input int bad, input bit poke, input bit glitch,
                         input logic [15:0] e_ans, input logic e_carry, input logic e_err);
    int n0, t0;
    bit got;
    logic [7:0] rb[3];
    rb[0] = r0; rb[1] = r1; rb[2] = r2;
    n0 = rsp_q.size();
    set_frame(a, b);
    do_request(a, b, t0);
    check_tx(0, 40*CPB - CPB/2, poke ? 100 : -1);
    fork
      check_tx(40*CPB - CPB/2, 40*CPB, -1);
      begin
        if (glitch) begin
          repeat (20) @(negedge clk);
          rx = 1'b0;
          repeat (4) @(negedge clk);
          rx = 1'b1;
          repeat (30) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
          send_byte(rb[k], k != bad);
          if (k == bad) break;
        end
      end
    join
    wait_rsp(n0, 200, got);
    if (got) begin
      check({name, "_ans"}, rsp_q[n0].ans, e_ans);
      check({name, "_carry"}, rsp_q[n0].carry, e_carry);
      check({name, "_err"}, rsp_q[n0].err, e_err);
    end
    repeat (4) @(negedge clk);
    check({name, "_pulses"}, rsp_q.size(), n0 + 1);
    check({name, "_ready_after"}, req_ready, 1);
  endtask

  initial begin #2000000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

  initial begin
    int n0, t0;
    bit got;
    logic [15:0] a, b;
    logic [16:0] sum;

    tbl[0] = '{16'h1234, 16'h0F0F, 8'h43, 8'h21, 8'h00, -1, 16'h2143, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 8'h00, 8'h00, 8'h01, -1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 8'h00, 8'h00, 8'hFE, -1, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h8001, 8'h01, 8'h00, 8'hFF, -1, 16'h0001, 1'b1, 1'b0};
    tbl[4] = '{16'h1111, 16'h2222, 8'h33, 8'h33, 8'h00,  1, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{16'h1111, 16'h2222, 8'h33, 8'h33, 8'h00, -1, 16'h3333, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_ans", rsp_ans, 0);
    check("rst_carry", rsp_carry, 0);
    check("rst_err", rsp_err, 0);
    rst_n = 1'b1;
    #1 check("rel_ready_before_clk", req_ready, 0);
    @(negedge clk);
    check("rel_ready", req_ready, 1);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].r0, tbl[i].r1, tbl[i].r2,
              tbl[i].bad, 1'b0, 1'b0, tbl[i].ans, tbl[i].carry, tbl[i].err);

    run_txn("glitch", 16'h0102, 16'h0304, 8'h06, 8'h04, 8'h00, -1, 1'b0, 1'b1, 16'h0406, 1'b0, 1'b0);
    run_txn("busy", 16'hABCD, 16'h1111, 8'hDE, 8'hBC, 8'h00, -1, 1'b1, 1'b0, 16'hBCDE, 1'b0, 1'b0);

    n0 = rsp_q.size();
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    repeat (40) @(negedge clk);
    check("stray_no_rsp", rsp_q.size(), n0);
    check("stray_ready", req_ready, 1);

    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      sum = {1'b0, a} + {1'b0, b};
      run_txn($sformatf("rand%0d", i), a, b, sum[7:0], sum[15:8],
              {7'($urandom), sum[16]}, -1, 1'b0, 1'b0, sum[15:0], sum[16], 1'b0);
    end

    run_txn("pre_to", 16'h4000, 16'h0123, 8'h23, 8'h41, 8'h00, -1, 1'b0, 1'b0, 16'h4123, 1'b0, 1'b0);
    n0 = rsp_q.size();
    set_frame(16'h5A5A, 16'h0101);
    do_request(16'h5A5A, 16'h0101, t0);
    check_tx(0, 40*CPB, -1);
    wait_rsp(n0, 600, got);
    if (got) begin
      check("to_latency", rsp_q[n0].at - t0, 40*CPB + TO);
      check("to_ans", rsp_q[n0].ans, 0);
      check("to_carry", rsp_q[n0].carry, 0);
      check("to_err", rsp_q[n0].err, 1);
    end
    repeat (2) @(negedge clk);
    check("to_pulses", rsp_q.size(), n0 + 1);
    check("to_ready", req_ready, 1);

    n0 = rsp_q.size();
    set_frame(16'hC3C3, 16'h3C3C);
    do_request(16'hC3C3, 16'h3C3C, t0);
    check_tx(0, 2*10*CPB + 5, -1);
    check("mid_tx_low", tx, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_ready_before_clk", req_ready, 0);
    @(negedge clk);
    check("mid_rel_ready", req_ready, 1);
    repeat (700) @(negedge clk);
    check("mid_no_rsp", rsp_q.size(), n0);
    check("mid_tx_idle", tx, 1);
    run_txn("post_rst", 16'h0F00, 16'h00F0, 8'hF0, 8'h0F, 8'h00, -1, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
